// File: rtl/rvcpu_pkg.sv
// rvcpu: shared types for the multiply/divide unit
package rvcpu;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } muldiv_op_t;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} muldiv_state_t;
endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: conditional two's-complement negate, used for operand magnitudes and result sign fixup
module muldiv_signfix #(
  parameter int Width = 32
) (
  input  logic [Width-1:0] i_val,
  input  logic             i_neg,
  output logic [Width-1:0] o_val
);
  assign o_val = i_neg ? -i_val : i_val;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide, one bit per cycle
module muldiv_unit import rvcpu::*; #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  muldiv_op_t       op,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] res,
  output logic             busy
);
  localparam int CW = $clog2(Width) + 1;
  muldiv_state_t r_state, w_next;
  muldiv_op_t r_op;
  logic [Width-1:0] r_hi, r_lo, r_b, r_res;
  logic [CW-1:0] r_cnt;
  logic r_neg_q, r_neg_r;
  logic w_accept, w_last, w_sa, w_sb, w_is_div, w_dz, w_ovf;
  logic [Width-1:0] w_abs_a, w_abs_b, w_mhi, w_mlo, w_dr, w_dq, w_q_fix, w_r_fix;
  logic [Width:0] w_sum, w_shl, w_diff;
  logic [2*Width-1:0] w_p_fix;
  assign in_ready  = r_state == ST_IDLE;
  assign out_valid = r_state == ST_DONE;
  assign busy      = r_state != ST_IDLE;
  assign res       = r_res;
  assign w_accept  = in_valid & in_ready & ~flush;
  assign w_is_div  = op[2];
  assign w_sa      = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign w_sb      = op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  assign w_dz      = w_is_div && b == '0;
  assign w_ovf     = w_is_div && w_sb && a == {1'b1, {(Width-1){1'b0}}} && &b;
  assign w_last    = r_cnt == CW'(Width - 1);
  // shift-add step: hi:lo holds partial product above the unconsumed multiplier bits
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_mhi = w_sum[Width:1];
  assign w_mlo = {w_sum[0], r_lo[Width-1:1]};
  // restoring step: hi is the partial remainder, lo shifts dividend out and quotient in
  assign w_shl  = {r_hi, r_lo[Width-1]};
  assign w_diff = w_shl - {1'b0, r_b};
  assign w_dr   = w_diff[Width] ? w_shl[Width-1:0] : w_diff[Width-1:0];
  assign w_dq   = {r_lo[Width-2:0], ~w_diff[Width]};
  muldiv_signfix #(.Width(Width)) u_abs_a (.i_val(a), .i_neg(w_sa & a[Width-1]), .o_val(w_abs_a));
  muldiv_signfix #(.Width(Width)) u_abs_b (.i_val(b), .i_neg(w_sb & b[Width-1]), .o_val(w_abs_b));
  muldiv_signfix #(.Width(2*Width)) u_prod (.i_val({w_mhi, w_mlo}), .i_neg(r_neg_q), .o_val(w_p_fix));
  muldiv_signfix #(.Width(Width)) u_quo (.i_val(w_dq), .i_neg(r_neg_q), .o_val(w_q_fix));
  muldiv_signfix #(.Width(Width)) u_rem (.i_val(w_dr), .i_neg(r_neg_r), .o_val(w_r_fix));
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  // next state: divide special cases skip iteration, flush overrides everything
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = !w_is_div ? ST_MUL : (w_dz | w_ovf) ? ST_DONE : ST_DIV;
      ST_MUL, ST_DIV: if (w_last) w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (flush) w_next = ST_IDLE;
  end
  // operand capture, one iteration per cycle, signed result latched on the final iteration
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_op    <= OP_MUL;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_res   <= '0;
    end else if (w_accept) begin
      r_op    <= op;
      r_hi    <= '0;
      r_lo    <= w_abs_a;
      r_b     <= w_abs_b;
      r_cnt   <= '0;
      r_neg_q <= (w_sa & a[Width-1]) ^ (w_sb & b[Width-1]);
      r_neg_r <= w_sa & a[Width-1];
      if (w_dz) r_res <= op[1] ? a : '1;
      else if (w_ovf) r_res <= op[1] ? '0 : a;
    end else if (r_state == ST_MUL || r_state == ST_DIV) begin
      r_cnt <= r_cnt + 1'b1;
      r_hi  <= r_state == ST_MUL ? w_mhi : w_dr;
      r_lo  <= r_state == ST_MUL ? w_mlo : w_dq;
      if (w_last)
        r_res <= r_state == ST_DIV ? (r_op[1] ? w_r_fix : w_q_fix) :
                 r_op == OP_MUL ? w_p_fix[Width-1:0] : w_p_fix[2*Width-1:Width];
    end
endmodule
